fir_normalize_pipe: RTL and testbench
=====================================

Name: fir_normalize_pipe

Overview:
- 2-stage valid/ready pipeline directly upstream of the FIR-to-posit packer.
- Takes an unnormalized arithmetic result (sign, total exponent, wide mantissa, sticky) from the core ops.
- Normalizes the mantissa, adjusts the total exponent and packs {sign, te, frac_full} plus the frac_lsb_cut_off flag, in exactly the format the packer consumes.
- Zero and NaR bypass flags travel alongside the data.

Parameters:
- N, 16, posit width.
- ES, 1, posit exponent field width.
- TE_SIZE, 8, signed total-exponent width (in and out).
- FRAC_FULL_SIZE, 24, output fraction width (hidden bit excluded).
- MANT_IN_SIZE, 26, input mantissa width. Bit MANT_IN_SIZE-1 is the overflow position; bit MANT_IN_SIZE-2 is the nominal hidden-one position. Must be ≥ FRAC_FULL_SIZE+1.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- in_valid  in  1  input beat valid.
- in_ready  out  1  stage can accept the beat.
- in_sign  in  1  result sign.
- in_te  in  TE_SIZE  signed total exponent, referenced to bit MANT_IN_SIZE-2.
- in_mant  in  MANT_IN_SIZE  unnormalized magnitude.
- in_sticky  in  1  OR of bits already discarded upstream.
- in_is_zero  in  1  result is zero.
- in_is_nar  in  1  result is NaR.
- out_valid  out  1  output beat valid.
- out_ready  in  1  downstream accepts.
- fir  out  1+TE_SIZE+FRAC_FULL_SIZE  {sign, te, frac_full}.
- frac_lsb_cut_off  out  1  OR of all fraction bits below frac_full, including in_sticky.
- out_is_zero  out  1  zero bypass.
- out_is_nar  out  1  NaR bypass.

Behaviour:
- Reset (async, rst=1): all valid bits are 0. All data registers, fir, frac_lsb_cut_off, out_is_zero and out_is_nar are 0. in_ready is 1 after reset deassertion. A beat in flight when reset asserts is discarded.
- Handshake:
  - A transfer occurs on a clock edge with valid&&ready.
  - out_valid and output data stay stable until out_ready.
  - No combinational path from in_valid to out_valid.
- Stage flow:
  - S1 advances when !s2_valid || out_ready.
  - in_ready = !s1_valid || s1_adv.
  - Full throughput of one beat per cycle.
  - Latency is 2 cycles from input transfer to out_valid with no stalls.
  - A stall holds both stages. Simultaneous accept and drain in the same cycle is legal and loses no beat.
- S1 (register):
  - Compute lz = leading-zero count of in_mant, 0..MANT_IN_SIZE.
  - Register sign, te, mant, sticky, lz and the flags.
- S2 (register):
  - norm = mant << lz.
  - te_out = te + 1 − lz, with signed TE_SIZE arithmetic and a TE_SIZE+1-bit intermediate.
  - frac_full = norm[MANT_IN_SIZE-2 -: FRAC_FULL_SIZE].
  - frac_lsb_cut_off = |norm[MANT_IN_SIZE-2-FRAC_FULL_SIZE:0] | sticky.
- Zero: if in_is_zero, or in_mant==0 and !in_sticky, then out_is_zero=1 and fir=0, cut_off=0, sign=0.
- NaR: if in_is_nar, then out_is_nar=1 and fir=0. NaR takes priority over zero.
- mant==0 with sticky=1 is treated as minimum magnitude: te_out = te − MANT_IN_SIZE + 1, frac_full=0, cut_off=1.
- Without clamping, te_out is truncated to TE_SIZE bits.

Optional Feature:
- Macro FIR_TE_CLAMP_EN, defined:
  - te_out is saturated to ±TE_MAX, where TE_MAX = (N-2)<<ES.
  - On saturation: frac_full=0 and cut_off=0, so the packer yields exactly maxpos or minpos.
  - Saturation uses the TE_SIZE+1-bit intermediate.
- Macro not defined: no clamp; behaviour is as above.

Decomposition:
- Package ppu_fir_pkg holds:
  - localparam helpers FIR_TOTAL_SIZE(TE_SIZE, FRAC_FULL_SIZE) and TE_MAX(N, ES);
  - the packed struct typedef for the fir fields {sign, te, frac_full}.
- One sub-module, fir_lzc: parameterized combinational leading-zero counter, WIDTH-bit in, $clog2(WIDTH+1)-bit count out, with all-zero input giving WIDTH.

Test Plan:
- Basic, N=16 ES=1 defaults:
  - in_mant=26'h2000000, te=3, sticky=0 → 2 cycles later te=4, frac_full=0, cut_off=0.
  - in_mant=26'h1000001, te=−2 → te=−2, frac_full=24'h000001, cut_off=0. Same beat with sticky=1 → cut_off=1.
- Deep normalize: in_mant=26'h0000003, te=0 → lz=24, te=−23, frac_full=24'h800000, cut_off=0.
- Backpressure:
  - Stream 8 beats with out_ready toggling 1,0,0,1,…: no loss, no duplication, order preserved, output stable while stalled.
  - With out_ready=1 constantly, sustained 1 beat per cycle.
- Specials:
  - in_is_zero=1 → out_is_zero=1, fir=0.
  - in_is_nar=1 with in_is_zero=1 → out_is_nar=1, out_is_zero=0.
- Reset mid-stream: assert rst with both stages full → out_valid=0 immediately (async). After release, in_ready=1 and no stale beat emerges.
- FIR_TE_CLAMP_EN: in_mant=26'h2000000, te=40 → te=28, frac_full=0, cut_off=0. te=−40 → te=−28. Without the macro, te=41 passes through.

Source files
------------

// File: rtl/fir_normalize_pipe_pkg.sv
// Shared types and sizing helpers for the FIR normalize stage ahead of the posit packer.
package ppu_fir_pkg;

  localparam int FIR_TE_W   = 8;
  localparam int FIR_FRAC_W = 24;

  function automatic int FIR_TOTAL_SIZE(input int te_size, input int frac_full_size);
    return 1 + te_size + frac_full_size;
  endfunction

  function automatic int TE_MAX(input int n, input int es);
    return (n - 2) << es;
  endfunction

  typedef struct packed {
    logic                        sign;
    logic signed [FIR_TE_W-1:0]  te;
    logic [FIR_FRAC_W-1:0]       frac_full;
  } fir_t;

endpackage

// File: rtl/fir_normalize_pipe_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fir_lzc #(
  parameter int WIDTH = 26,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] value,
  output logic [CW-1:0]    count
);

  // Scanning upward leaves the position of the highest set bit as the final hit.
  always_comb begin
    count = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) begin
      if (value[i]) count = CW'(WIDTH - 1 - i);
    end
  end

endmodule

// File: rtl/fir_normalize_pipe.sv
// Two-stage valid/ready normalizer producing {sign, te, frac_full} plus cut-off flag for the packer.
// Define FIR_TE_CLAMP_EN to saturate te_out to +/-TE_MAX (packer then yields maxpos/minpos).
module fir_normalize_pipe
  import ppu_fir_pkg::*;
#(
  parameter int N              = 16,
  parameter int ES             = 1,
  parameter int TE_SIZE        = 8,
  parameter int FRAC_FULL_SIZE = 24,
  parameter int MANT_IN_SIZE   = 26
) (
  input  logic                                                clk,
  input  logic                                                rst,
  input  logic                                                in_valid,
  output logic                                                in_ready,
  input  logic                                                in_sign,
  input  logic [TE_SIZE-1:0]                                  in_te,
  input  logic [MANT_IN_SIZE-1:0]                             in_mant,
  input  logic                                                in_sticky,
  input  logic                                                in_is_zero,
  input  logic                                                in_is_nar,
  output logic                                                out_valid,
  input  logic                                                out_ready,
  output logic [FIR_TOTAL_SIZE(TE_SIZE, FRAC_FULL_SIZE)-1:0]  fir,
  output logic                                                frac_lsb_cut_off,
  output logic                                                out_is_zero,
  output logic                                                out_is_nar
);

  localparam int LZ_W = $clog2(MANT_IN_SIZE + 1);
  localparam int TW   = TE_SIZE + 1;
  localparam logic signed [TE_SIZE:0] TE_HI = TW'(TE_MAX(N, ES));
  localparam logic signed [TE_SIZE:0] TE_LO = -TE_HI;
`ifdef FIR_TE_CLAMP_EN
  localparam bit CLAMP_EN = 1'b1;
`else
  localparam bit CLAMP_EN = 1'b0;
`endif

  logic                    s1_valid, s1_sign, s1_sticky, s1_zero, s1_nar;
  logic [TE_SIZE-1:0]      s1_te;
  logic [MANT_IN_SIZE-1:0] s1_mant;
  logic [LZ_W-1:0]         s1_lz, lz;
  logic                    s2_valid, s1_adv;

  fir_lzc #(.WIDTH(MANT_IN_SIZE), .CW(LZ_W)) u_lzc (
    .value (in_mant),
    .count (lz)
  );

  assign s1_adv    = !s2_valid || out_ready;
  assign in_ready  = !s1_valid || s1_adv;
  assign out_valid = s2_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s1_sign   <= 1'b0;
      s1_te     <= '0;
      s1_mant   <= '0;
      s1_sticky <= 1'b0;
      s1_lz     <= '0;
      s1_zero   <= 1'b0;
      s1_nar    <= 1'b0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_sign   <= in_sign;
        s1_te     <= in_te;
        s1_mant   <= in_mant;
        s1_sticky <= in_sticky;
        s1_lz     <= lz;
        s1_zero   <= in_is_zero || (in_mant == '0 && !in_sticky);
        s1_nar    <= in_is_nar;
      end
    end
  end

  logic [MANT_IN_SIZE-2:0]   norm_low;
  logic signed [TE_SIZE:0]   te_wide;
  logic                      sign_next, cut_next;
  logic [TE_SIZE-1:0]        te_next;
  logic [FRAC_FULL_SIZE-1:0] frac_next;

  // The overflow bit of the normalized mantissa is the hidden one and is dropped here.
  always_comb begin
    norm_low  = (MANT_IN_SIZE-1)'(s1_mant << s1_lz);
    te_wide   = {s1_te[TE_SIZE-1], s1_te} + TW'(1) - TW'(s1_lz);
    sign_next = s1_sign;
    te_next   = te_wide[TE_SIZE-1:0];
    frac_next = norm_low[MANT_IN_SIZE-2 -: FRAC_FULL_SIZE];
    cut_next  = (|norm_low[MANT_IN_SIZE-2-FRAC_FULL_SIZE:0]) | s1_sticky;
    if (CLAMP_EN && te_wide > TE_HI) begin
      te_next   = TE_HI[TE_SIZE-1:0];
      frac_next = '0;
      cut_next  = 1'b0;
    end else if (CLAMP_EN && te_wide < TE_LO) begin
      te_next   = TE_LO[TE_SIZE-1:0];
      frac_next = '0;
      cut_next  = 1'b0;
    end
    if (s1_nar || s1_zero) begin
      sign_next = 1'b0;
      te_next   = '0;
      frac_next = '0;
      cut_next  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid         <= 1'b0;
      fir              <= '0;
      frac_lsb_cut_off <= 1'b0;
      out_is_zero      <= 1'b0;
      out_is_nar       <= 1'b0;
    end else if (s1_adv) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        fir              <= {sign_next, te_next, frac_next};
        frac_lsb_cut_off <= cut_next;
        out_is_zero      <= s1_zero && !s1_nar;
        out_is_nar       <= s1_nar;
      end
    end
  end

endmodule

// File: tb/tb_fir_normalize_pipe.sv
// Self-checking bench for fir_normalize_pipe: vector table, scoreboard streams, stall and reset cases.
module tb_fir_normalize_pipe;
  import ppu_fir_pkg::*;

  logic        clk = 1'b0, rst = 1'b1;
  logic        in_valid = 1'b0, in_sign = 1'b0, in_sticky = 1'b0;
  logic        in_is_zero = 1'b0, in_is_nar = 1'b0, out_ready = 1'b0;
  logic [7:0]  in_te = '0;
  logic [25:0] in_mant = '0;
  logic        in_ready, out_valid, frac_lsb_cut_off, out_is_zero, out_is_nar;
  logic [32:0] fir;

  fir_normalize_pipe dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_te(in_te), .in_mant(in_mant), .in_sticky(in_sticky),
    .in_is_zero(in_is_zero), .in_is_nar(in_is_nar), .out_valid(out_valid),
    .out_ready(out_ready), .fir(fir), .frac_lsb_cut_off(frac_lsb_cut_off),
    .out_is_zero(out_is_zero), .out_is_nar(out_is_nar)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    fir_t f;
    logic cut;
    logic z;
    logic n;
  } exp_t;

  typedef struct {
    logic              sign;
    logic signed [7:0] te;
    logic [25:0]       mant;
    logic              sticky, zero, nar;
    exp_t              exp;
  } beat_t;

  beat_t in_q[$];
  exp_t  exp_q[$];
  beat_t vecs[$];
  int    n_checks = 0, n_errors = 0, n_out = 0;
  bit    hold_valid = 1'b0;
  exp_t  hold_val;

  function automatic exp_t cur_out();
    return exp_t'({fir, frac_lsb_cut_off, out_is_zero, out_is_nar});
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Reference: locate the leading one, then slice the 24 bits that follow it.
  function automatic exp_t model(input logic sign, input logic signed [7:0] te, input logic [25:0] mant,
                                 input logic sticky, input logic zero, input logic nar);
    exp_t        e;
    int          p, te_w;
    logic [63:0] m;
    logic [23:0] frac;
    logic        cut;
    e = '0;
    p = -1;
    m = 64'(mant);
    for (int i = 0; i < 26; i++) if (mant[i]) p = i;
    if (nar) begin e.n = 1'b1; return e; end
    if (zero || (p < 0 && !sticky)) begin e.z = 1'b1; return e; end
    if (p < 0) begin
      te_w = int'(te) - 25; frac = '0; cut = 1'b1;
    end else begin
      te_w = int'(te) + p - 24;
      if (p >= 24) begin
        frac = 24'(m >> (p - 24));
        cut  = sticky | ((m & ((64'd1 << (p - 24)) - 64'd1)) != 0);
      end else begin
        frac = 24'(m << (24 - p));
        cut  = sticky;
      end
    end
`ifdef FIR_TE_CLAMP_EN
    if (te_w > 28) begin te_w = 28; frac = '0; cut = 1'b0; end
    if (te_w < -28) begin te_w = -28; frac = '0; cut = 1'b0; end
`endif
    e.f   = fir_t'({sign, 8'(te_w), frac});
    e.cut = cut;
    return e;
  endfunction

  function automatic beat_t mkb(input logic sign, input logic signed [7:0] te, input logic [25:0] mant,
                                input logic sticky, input logic zero, input logic nar,
                                input logic [32:0] f, input logic cut, input logic z, input logic n);
    beat_t b;
    b.sign = sign; b.te = te; b.mant = mant; b.sticky = sticky; b.zero = zero; b.nar = nar;
    b.exp = exp_t'({f, cut, z, n});
    return b;
  endfunction

  function automatic beat_t rnd_beat();
    beat_t b;
    b.sign   = 1'($urandom);
    b.te     = 8'($urandom);
    b.mant   = 26'($urandom) >> $urandom_range(0, 26);
    b.sticky = 1'($urandom);
    b.zero   = ($urandom_range(0, 9) == 0);
    b.nar    = ($urandom_range(0, 9) == 0);
    b.exp    = model(b.sign, b.te, b.mant, b.sticky, b.zero, b.nar);
    return b;
  endfunction

  task automatic step(input bit rdy);
    @(negedge clk);
    out_ready = rdy;
    if (in_q.size() > 0) begin
      in_valid = 1'b1; in_sign = in_q[0].sign; in_te = in_q[0].te; in_mant = in_q[0].mant;
      in_sticky = in_q[0].sticky; in_is_zero = in_q[0].zero; in_is_nar = in_q[0].nar;
    end else begin
      in_valid = 1'b0;
    end
    #1;
    if (hold_valid) chk("stall_hold", {out_valid, cur_out()}, {1'b1, hold_val});
    hold_valid = out_valid && !out_ready;
    hold_val   = cur_out();
    if (out_valid && out_ready) begin
      n_out++;
      chk("beat_expected", 64'(exp_q.size() > 0), 64'd1);
      if (exp_q.size() > 0) chk("beat", cur_out(), exp_q.pop_front());
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(in_q[0].exp);
      void'(in_q.pop_front());
    end
  endtask

  task automatic drain(input bit pattern);
    int c;
    c = 0;
    while ((in_q.size() + exp_q.size()) > 0 && c < 400) begin
      step(pattern ? ((c % 4 == 0) || (c % 4 == 3)) : 1'b1);
      c++;
    end
    chk("drain_done", 64'(in_q.size() + exp_q.size()), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int o0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_state", {out_valid, in_ready, fir, frac_lsb_cut_off, out_is_zero, out_is_nar},
        {1'b0, 1'b1, 33'd0, 3'b000});

    vecs.push_back(mkb(0,  8'sd3,   26'h2000000, 0, 0, 0, {1'b0, 8'h04, 24'h000000}, 0, 0, 0));
    vecs.push_back(mkb(0, -8'sd2,   26'h1000001, 0, 0, 0, {1'b0, 8'hFE, 24'h000001}, 0, 0, 0));
    vecs.push_back(mkb(0, -8'sd2,   26'h1000001, 1, 0, 0, {1'b0, 8'hFE, 24'h000001}, 1, 0, 0));
    vecs.push_back(mkb(0,  8'sd0,   26'h0000003, 0, 0, 0, {1'b0, 8'hE9, 24'h800000}, 0, 0, 0));
    vecs.push_back(mkb(1,  8'sd5,   26'h1000000, 0, 0, 0, {1'b1, 8'h05, 24'h000000}, 0, 0, 0));
    vecs.push_back(mkb(0,  8'sd0,   26'h3FFFFFF, 0, 0, 0, {1'b0, 8'h01, 24'hFFFFFF}, 1, 0, 0));
    vecs.push_back(mkb(0,  8'sd0,   26'h0000001, 0, 0, 0, {1'b0, 8'hE8, 24'h000000}, 0, 0, 0));
    vecs.push_back(mkb(1,  8'sd7,   26'h1234567, 1, 1, 0, 33'd0, 0, 1, 0));
    vecs.push_back(mkb(1,  8'sd7,   26'h1234567, 0, 1, 1, 33'd0, 0, 0, 1));
    vecs.push_back(mkb(1,  8'sd9,   26'h0000000, 0, 0, 0, 33'd0, 0, 1, 0));
    vecs.push_back(mkb(1,  8'sd10,  26'h0000000, 1, 0, 0, {1'b1, 8'hF1, 24'h000000}, 1, 0, 0));
`ifdef FIR_TE_CLAMP_EN
    vecs.push_back(mkb(0,  8'sd40,  26'h2000000, 0, 0, 0, {1'b0, 8'h1C, 24'h000000}, 0, 0, 0));
    vecs.push_back(mkb(0, -8'sd40,  26'h2000000, 0, 0, 0, {1'b0, 8'hE4, 24'h000000}, 0, 0, 0));
    vecs.push_back(mkb(0,  8'sd127, 26'h2000001, 1, 0, 0, {1'b0, 8'h1C, 24'h000000}, 0, 0, 0));
    vecs.push_back(mkb(0,  8'sd26,  26'h2000002, 0, 0, 0, {1'b0, 8'h1B, 24'h000001}, 0, 0, 0));
`else
    vecs.push_back(mkb(0,  8'sd41,  26'h2000000, 0, 0, 0, {1'b0, 8'h2A, 24'h000000}, 0, 0, 0));
    vecs.push_back(mkb(0, -8'sd40,  26'h2000000, 0, 0, 0, {1'b0, 8'hD9, 24'h000000}, 0, 0, 0));
    vecs.push_back(mkb(0,  8'sd127, 26'h2000001, 1, 0, 0, {1'b0, 8'h80, 24'h000000}, 1, 0, 0));
`endif

    for (int i = 0; i < vecs.size(); i++) begin
      in_q.push_back(vecs[i]);
      step(1'b1);
    end
    drain(1'b0);

    // First-beat latency: visible on the second edge after acceptance.
    in_q.push_back(rnd_beat());
    step(1'b1);
    step(1'b1);
    chk("latency_c1", 64'(out_valid), 64'd0);
    step(1'b1);
    chk("latency_c2", 64'(out_valid), 64'd1);
    drain(1'b0);

    o0 = n_out;
    for (int i = 0; i < 16; i++) in_q.push_back(rnd_beat());
    for (int i = 0; i < 18; i++) step(1'b1);
    chk("throughput_beats", 64'(n_out - o0), 64'd16);
    chk("throughput_empty", 64'(in_q.size() + exp_q.size()), 64'd0);

    for (int i = 0; i < 8; i++) in_q.push_back(rnd_beat());
    drain(1'b1);
    for (int i = 0; i < 40; i++) in_q.push_back(rnd_beat());
    drain(1'b1);

    for (int i = 0; i < 4; i++) in_q.push_back(rnd_beat());
    step(1'b0);
    step(1'b0);
    step(1'b0);
    chk("full_before_rst", {out_valid, in_ready}, 2'b10);
    rst = 1'b1;
    #1;
    chk("rst_async", {out_valid, fir, frac_lsb_cut_off, out_is_zero, out_is_nar}, 37'd0);
    in_q.delete();
    exp_q.delete();
    hold_valid = 1'b0;
    in_valid   = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    o0 = n_out;
    for (int i = 0; i < 6; i++) step(1'b1);
    chk("no_stale_beat", 64'(n_out - o0), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
